score_display: RTL and testbench
================================

# score_display

Drives the board's 4-digit multiplexed seven-segment display from the 8-bit game score that `score_evaluation` produces. The score bus is the far end of the score path, and this block is its consumer. It converts binary to BCD sequentially (shift-add-3, one bit per cycle), holds the result, and time-multiplexes three decimal digits onto active-low segment and anode lines with leading-zero blanking. It instantiates in `main` beside `led_display`, fed by the `score` wire.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit slot is held (1 ms at 100 MHz). Legal range 2 to 2^20. Benches use 4.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `score`  input  8  unsigned binary score, 0 to 255, level (no strobe)
- `seg`  output  7  segment cathodes, active-low; bit6=g … bit0=a
- `an`  output  4  digit anodes, active-low; an[0] = ones (rightmost)
- `dp`  output  1  decimal point, active-low; constant 1 (off)
- `busy`  output  1  high while a conversion is in progress

## Operation
- **Registers:** `last_score[7:0]` (last converted value), `bcd_h/t/o[3:0]` (committed digits), 20-bit shift register {h,t,o,bin}, 3-bit shift count, FSM state.
- **FSM IDLE:** if `score != last_score`, load the shift register with {12'b0, `score`}, capture `score` into a pending register, clear the count, and go to SHIFT. Otherwise stay in IDLE.
- **FSM SHIFT:** each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1. After the 8th shift, go to DONE.
- **FSM DONE:** copy the nibbles into `bcd_h/t/o`, set `last_score` to the pending value, and return to IDLE.
- **Busy:** `busy` = (state == SHIFT) || (state == DONE).
- **Score changes during SHIFT/DONE:** ignored. The in-flight conversion completes with the captured value. IDLE then sees the mismatch and starts a new conversion the next cycle. There is no loss and no partial display.
- **Refresh counter:** counts 0 to REFRESH_DIV-1 and wraps. On wrap, the 2-bit slot index increments 0→1→2→3→0.
- **Slot 0:** ones digit, always lit, an=4'b1110.
- **Slot 1:** tens digit, an=4'b1101. Blanked (an=4'b1111) when bcd_h==0 and bcd_t==0.
- **Slot 2:** hundreds digit, an=4'b1011. Blanked when bcd_h==0.
- **Slot 3:** always blank, an=4'b1111 and seg=7'h7F. This keeps the duty cycle constant.
- **Segment map (active-low gfedcba):** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble gives 1111111.
- **Blanked slot:** seg=1111111 as well as an=1111.
- **Outputs:** `seg`, `an`, `dp` are registered, with one cycle from slot/BCD state to pins. There are no combinational paths from inputs to outputs.

## Timing
- **Reset values (async assert):** seg=7'b1111111, an=4'b1111, dp=1, busy=0, state=IDLE, last_score=0, bcd_h/t/o=0, slot=0, refresh=0.
- **First edge after reset release:** an=4'b1110, seg=7'b1000000 (displays "0"). If `score` is nonzero at release, conversion starts on that same edge.
- **Conversion latency:** `score` changes while IDLE at edge N.
  - Edges N+1 to N+8: SHIFT.
  - Edge N+9: DONE.
  - Edge N+10: `bcd_*` updated.
  - Edge N+11: new digit on `seg` if its slot is active.
  - `busy` is high for exactly 9 cycles.
- **Refresh period:** each slot lasts exactly REFRESH_DIV cycles, and a full scan takes 4·REFRESH_DIV cycles. Conversion never stalls the refresh.
- **Reset mid-conversion:** aborts immediately. After release, the block re-converts if `score` ≠ 0.
- **Simultaneous events:** a score change and DONE on the same edge resolve as commit first, then the new conversion starts from IDLE on the next edge.

## Test plan
- **Reset:** assert `rst` with score=0, then release → an=1110, seg=1000000, busy=0. Across slots 1–3 an=1111. dp=1 throughout.
- **Full range:** score=255, REFRESH_DIV=4 → busy high for exactly 9 cycles. Then slot0 seg=0010010 (5), slot1 seg=0010010 (5), slot2 seg=0100100 (2), slot3 an=1111.
- **Leading-zero blanking:** score=7 → only an[0] ever low, seg=1111000. Score=100 → slot1 shows 0 (1000000) because hundreds≠0, and slot2 shows 1 (1111001).
- **Mid-conversion change:** score=12, then 34 on the 3rd SHIFT cycle → digits 1,2 commit. A second 9-cycle busy window follows, then digits 3,4. Total time from the first change to final commit is 20 cycles.
- **Reset mid-conversion:** score=200, assert `rst` on the 5th SHIFT cycle → all outputs take reset values asynchronously. After release, busy is high 9 cycles, then the display shows 2,0,0.
- **Refresh count:** with REFRESH_DIV=4, count edges between anode changes → exactly 4 per slot and 16 per full scan over 10 scans.

Source files
------------

// File: rtl/score_display.sv
// score_display: binary-to-BCD conversion of the 8-bit game score and a
// three-digit multiplexed seven-segment driver with leading-zero blanking.
// All display pins are registered; the fourth slot is always dark so every
// digit keeps the same duty cycle.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]    state;
    logic [19:0]   shift_reg;     // {hundreds, tens, ones, binary}
    logic [2:0]    shift_cnt;
    logic [7:0]    pending;
    logic [7:0]    last_score;
    logic [3:0]    bcd_h, bcd_t, bcd_o;

    logic [CW-1:0] refresh;
    logic [1:0]    slot;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    // Add 3 to each BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [19:0] add3_nibbles(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        if (v[19:16] >= 4'd5) r[19:16] = v[19:16] + 4'd3;
        if (v[15:12] >= 4'd5) r[15:12] = v[15:12] + 4'd3;
        if (v[11:8]  >= 4'd5) r[11:8]  = v[11:8]  + 4'd3;
        return r;
    endfunction

    // Active-low gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Conversion FSM: detect a new score, shift-add-3 eight times, commit.
    // NOTE: every register here is reset, including the data path, so the
    // display shows a clean "0" right after reset and the change detector
    // re-triggers for any nonzero score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            shift_cnt  <= '0;
            pending    <= '0;
            last_score <= '0;
            bcd_h      <= '0;
            bcd_t      <= '0;
            bcd_o      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout clocked logic so every
            // register samples the pre-edge values of its neighbours.
            case (state)
                ST_IDLE: begin
                    if (score != last_score) begin
                        shift_reg <= {12'b0, score};
                        pending   <= score;
                        shift_cnt <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= add3_nibbles(shift_reg) << 1;
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7) state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd_h      <= shift_reg[19:16];
                    bcd_t      <= shift_reg[15:12];
                    bcd_o      <= shift_reg[11:8];
                    last_score <= pending;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT) || (state == ST_DONE);
    assign dp   = 1'b1;

    // Refresh divider and digit-slot rotation, independent of conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            slot    <= '0;
        end else if (refresh == REF_LAST) begin
            refresh <= '0;
            slot    <= slot + 2'd1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    // Pick the digit and anode for the current slot, applying blanking.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latch).
        digit  = bcd_o;
        blank  = 1'b0;
        an_nxt = 4'b1111;
        case (slot)
            2'd0: begin
                digit  = bcd_o;
                an_nxt = 4'b1110;
            end
            2'd1: begin
                digit  = bcd_t;
                blank  = (bcd_h == 4'd0) && (bcd_t == 4'd0);
                an_nxt = 4'b1101;
            end
            2'd2: begin
                digit  = bcd_h;
                blank  = (bcd_h == 4'd0);
                an_nxt = 4'b1011;
            end
            default: blank = 1'b1;
        endcase
        if (blank) an_nxt = 4'b1111;
        seg_nxt = blank ? SEG_BLANK : seg_of(digit);
    end

    // Register the pins so nothing reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed testbench for score_display with REFRESH_DIV = 4.
module tb_score_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] score;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;   // clock edges since the last reset release

    logic [6:0] seg_s[4];
    logic [3:0] an_s[4];

    int         bcyc;
    int         windows, hi_cnt, done_t;
    logic       prev_busy;
    int         run, bad_run, changes, bad_scan, last_e;
    logic [3:0] prev_an;

    score_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .seg   (seg),
        .an    (an),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sixteen edges; output at edge k belongs to slot ((k-1)/4) mod 4.
    task automatic scan();
        for (int i = 0; i < 16; i++) begin
            tick();
            seg_s[((cyc - 1) >> 2) & 3] = seg;
            an_s[((cyc - 1) >> 2) & 3]  = an;
        end
    endtask

    task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [3:0] a1, input logic [3:0] a2);
        scan();
        check({tag, "_s0_an"},  an_s[0],  4'b1110);
        check({tag, "_s0_seg"}, seg_s[0], s0);
        check({tag, "_s1_an"},  an_s[1],  a1);
        check({tag, "_s1_seg"}, seg_s[1], s1);
        check({tag, "_s2_an"},  an_s[2],  a2);
        check({tag, "_s2_seg"}, seg_s[2], s2);
        check({tag, "_s3_an"},  an_s[3],  4'b1111);
        check({tag, "_s3_seg"}, seg_s[3], 7'b1111111);
        check({tag, "_dp"},     dp,       1'b1);
    endtask

    // Wait for a busy window and count its length in cycles.
    task automatic wait_conv(input string tag, output int busy_cycles);
        int t;
        t = 0;
        busy_cycles = 0;
        while (!busy && t < 60) begin tick(); t++; end
        while (busy && t < 60) begin busy_cycles++; tick(); t++; end
        if (t >= 60) check({tag, "_timeout"}, t, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst   = 1'b1;
        score = 8'd0;
        #1;
        check("rst_seg",  seg,  7'b1111111);
        check("rst_an",   an,   4'b1111);
        check("rst_dp",   dp,   1'b1);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tick();
        check("rel_an",   an,   4'b1110);
        check("rel_seg",  seg,  7'b1000000);
        check("rel_busy", busy, 1'b0);
        check_scan("zero", 7'b1000000, 7'b1111111, 7'b1111111, 4'b1111, 4'b1111);

        // Full range: 255
        score = 8'd255;
        wait_conv("ff", bcyc);
        check("ff_busy_len", bcyc, 9);
        tick();
        check_scan("ff", 7'b0010010, 7'b0010010, 7'b0100100, 4'b1101, 4'b1011);

        // Leading-zero blanking: 7 then 100
        score = 8'd7;
        wait_conv("s7", bcyc);
        check("s7_busy_len", bcyc, 9);
        tick();
        check_scan("s7", 7'b1111000, 7'b1111111, 7'b1111111, 4'b1111, 4'b1111);

        score = 8'd100;
        wait_conv("s100", bcyc);
        tick();
        check_scan("s100", 7'b1000000, 7'b1000000, 7'b1111001, 4'b1101, 4'b1011);

        // Change mid-conversion: 12, then 34 while shifting
        score     = 8'd12;
        windows   = 0;
        hi_cnt    = 0;
        done_t    = -1;
        prev_busy = 1'b0;
        for (int t = 1; t <= 60 && done_t < 0; t++) begin
            tick();
            if (t == 3) score = 8'd34;
            if (busy) hi_cnt++;
            if (busy && !prev_busy) windows++;
            if (!busy && prev_busy && windows == 2) done_t = t;
            prev_busy = busy;
        end
        check("mid_windows", windows, 2);
        check("mid_busy_total", hi_cnt, 18);
        check("mid_latency", done_t, 20);
        tick();
        check_scan("s34", 7'b0011001, 7'b0110000, 7'b1111111, 4'b1101, 4'b1111);

        // Reset in the middle of a conversion of 200
        score = 8'd200;
        repeat (5) tick();
        check("r200_busy_pre", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rmid_seg",  seg,  7'b1111111);
        check("rmid_an",   an,   4'b1111);
        check("rmid_busy", busy, 1'b0);
        check("rmid_dp",   dp,   1'b1);
        @(posedge clk);
        #1;
        check("rmid_hold_an", an, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tick();
        check("r200_first_an",  an,   4'b1110);
        check("r200_first_seg", seg,  7'b1000000);
        wait_conv("r200", bcyc);
        check("r200_busy_len", bcyc, 9);
        tick();
        check_scan("r200", 7'b1000000, 7'b1000000, 7'b0100100, 4'b1101, 4'b1011);

        // Refresh timing: every anode run is 4 edges, every full scan 16
        run      = 0;
        bad_run  = 0;
        changes  = 0;
        bad_scan = 0;
        last_e   = -1;
        prev_an  = an;
        for (int i = 0; i < 170; i++) begin
            tick();
            run++;
            if (an !== prev_an) begin
                if (changes > 0 && run != 4) bad_run++;
                changes++;
                run = 0;
                if (an == 4'b1110) begin
                    if (last_e >= 0 && i - last_e != 16) bad_scan++;
                    last_e = i;
                end
            end
            prev_an = an;
        end
        check("refresh_bad_runs",  bad_run,  0);
        check("refresh_bad_scans", bad_scan, 0);
        check("refresh_changes",   changes >= 40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
